// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared size encodings, controller state enum and RAM size
//                default for the data-RAM access path. The RAM uses the same
//                size encodings as the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encodings shared with the RAM
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Default RAM size in bytes
  localparam int MEM_BYTES_DEFAULT = 1024;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Number of bytes a request spans: count words for word size, else one
  // access of 2^size bytes. 33 bits wide so the end-address sum cannot wrap.
  function automatic logic [32:0] access_span(input logic [1:0] size,
                                              input logic [3:0] count);
    if (size == SZ_WORD) begin
      return {27'd0, count, 2'b00};
    end
    return 33'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lane_align
//  Description : Combinational byte-lane handling. Replicates right-justified
//                store data onto every lane the RAM might select, and sign-
//                or zero-extends right-justified load data to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wlanes,
  output logic [31:0] o_rext
);

  // Lane replication for stores and extension for loads, selected by size
  always_comb begin
    o_wlanes = i_wdata;
    o_rext   = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_wlanes = {4{i_wdata[7:0]}};
        o_rext   = {{24{i_signed & i_rdata[7]}}, i_rdata[7:0]};
      end
      SZ_HALF: begin
        o_wlanes = {2{i_wdata[15:0]}};
        o_rext   = {{16{i_signed & i_rdata[15]}}, i_rdata[15:0]};
      end
      default: begin
        o_wlanes = i_wdata;
        o_rext   = i_rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_ctrl
//  Description : Initiator-side access controller for the byte-lane single-
//                port data RAM. Checks alignment and bounds of load/store
//                requests, sequences single or word-burst RAM accesses and
//                returns extended load data or a store ack / fault response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  // request from execute stage
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_count,
  // store data stream
  input  logic        i_wdata_valid,
  output logic        o_wdata_ready,
  input  logic [31:0] i_wdata,
  // response to core
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_last,
  output logic        o_rsp_fault,
  // RAM port
  output logic [1:0]  o_ram_size,
  output logic        o_ram_we,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;      // current beat address
  logic [3:0]  r_count;     // beats remaining, including the current one
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_last;
  logic        r_rsp_fault;
  logic [31:0] r_ram_addr;
  logic [1:0]  r_ram_size;

  logic [32:0] w_end;
  logic        w_fault;
  logic        w_beat;
  logic [31:0] w_wlanes;
  logic [31:0] w_rext;
  logic [31:0] w_next_addr;

  lane_align u_lane_align (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (i_wdata),
    .i_rdata  (i_ram_rdata),
    .o_wlanes (w_wlanes),
    .o_rext   (w_rext)
  );

  // End of the byte range touched by the request, one past the last byte
  assign w_end = {1'b0, r_addr} + access_span(r_size, r_count);

  // Request legality: encoding, alignment, burst rules and RAM bounds
  always_comb begin
    w_fault = 1'b0;
    if (r_size == 2'b11)                            w_fault = 1'b1;
    if (r_size == SZ_HALF && r_addr[0])             w_fault = 1'b1;
    if (r_size == SZ_WORD && r_addr[1:0] != 2'b00)  w_fault = 1'b1;
    if (r_count == 4'd0 || r_count > 4'(MAX_BURST)) w_fault = 1'b1;
    if (r_count > 4'd1 && r_size != SZ_WORD)        w_fault = 1'b1;
    if (w_end > 33'(MEM_BYTES))                     w_fault = 1'b1;
  end

  assign w_next_addr = r_addr + 32'd4;
  assign w_beat      = (r_state == ST_WRITE) && i_wdata_valid;

  assign o_req_ready   = (r_state == ST_IDLE)  && !rst;
  assign o_wdata_ready = (r_state == ST_WRITE) && !rst;
  assign o_ram_we      = w_beat && !rst;
  assign o_ram_wdata   = ((r_state == ST_WRITE) && !rst) ? w_wlanes : 32'd0;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_size    = r_ram_size;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_last    = r_rsp_last;
  assign o_rsp_fault   = r_rsp_fault;

  // Request FSM with beat counter, address incrementer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_size      <= SZ_WORD;
      r_signed    <= 1'b0;
      r_addr      <= 32'd0;
      r_count     <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_last  <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_ram_addr  <= 32'd0;
      r_ram_size  <= SZ_WORD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_write  <= i_req_write;
            r_size   <= i_req_size;
            r_signed <= i_req_signed;
            r_addr   <= i_req_addr;
            r_count  <= i_req_count;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_fault) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_state     <= ST_RESP;
          end else begin
            r_ram_addr <= r_addr;
            r_ram_size <= r_size;
            r_state    <= r_write ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_rsp_data  <= w_rext;
          r_rsp_last  <= (r_count == 4'd1);
          r_rsp_fault <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_WRITE: begin
          if (i_wdata_valid) begin
            if (r_count == 4'd1) begin
              r_rsp_data  <= 32'd0;
              r_rsp_last  <= 1'b1;
              r_rsp_fault <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_count    <= r_count - 4'd1;
              r_addr     <= w_next_addr;
              r_ram_addr <= w_next_addr;
            end
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (!r_write && !r_rsp_fault && r_count > 4'd1) begin
              r_count    <= r_count - 4'd1;
              r_addr     <= w_next_addr;
              r_ram_addr <= w_next_addr;
              r_state    <= ST_READ;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator-side access controller for the byte-lane single-port data RAM. It accepts load/store requests from the core's execute stage and checks alignment and bounds. Each request becomes one or more sized RAM accesses: single transfers or LDM/STM-style word bursts. The block replicates store data onto the correct byte lanes and sign- or zero-extends load data before returning it to the core.

## Interface
- MEM_BYTES, 1024: RAM size in bytes; any beat at or above this address faults.
- MAX_BURST, 8: maximum beats per request.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid / req_ready  in / out  1  request handshake; accepted on the edge where both are high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load result (byte/half only).
- req_addr  in  32  byte address of the first beat.
- req_count  in  4  beat count, 1..MAX_BURST; a count above 1 requires word size.
- wdata_valid / wdata_ready  in / out  1  store-data stream, one word per write beat.
- wdata  in  32  store data, right-justified.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_data  out  32  extended load data; 0 for store ack and for faults.
- rsp_last  out  1  final response of the request.
- rsp_fault  out  1  request rejected; no RAM access was made.
- ram_size  out  2  to RAM size.
- ram_we  out  1  to RAM write_enable.
- ram_addr  out  32  to RAM address.
- ram_wdata  out  32  to RAM write_data.
- ram_rdata  in  32  from RAM read_data.
  - RAM read data is registered: it is valid the cycle after the address is presented.
  - RAM read data is right-justified and zero-filled.

## Operation
- States: IDLE, CHECK, READ, CAPT, WRITE, RESP.
- IDLE
  - req_ready = 1 (forced 0 while rst is high).
  - On accept, register write, size, signed, addr, count, then go to CHECK.
- CHECK (1 cycle) raises a fault on any of:
  - size 11;
  - size 01 with addr[0] = 1;
  - size 10 with addr[1:0] ≠ 00;
  - count 0, or count > MAX_BURST;
  - count > 1 with size ≠ 10;
  - addr + count·4 (word) or addr + 2^size (single) exceeding MEM_BYTES. Compute this sum 33 bits wide so it cannot wrap.
- CHECK next state:
  - fault → RESP with rsp_fault = 1, rsp_last = 1, rsp_data = 0;
  - otherwise → READ for a load, WRITE for a store.
- READ
  - Drive ram_addr = beat address, ram_size = req_size, ram_we = 0.
  - Next state CAPT.
- CAPT
  - Drive ram_addr and ram_size unchanged.
  - At the end of the cycle, register the extended ram_rdata into rsp_data.
    - byte: {24{signed & d[7]}, d[7:0]};
    - half: {16{signed & d[15]}, d[15:0]};
    - word: unchanged.
  - Next state RESP.
- WRITE
  - wdata_ready = 1.
  - ram_we = wdata_valid (combinational); ram_addr = beat address; ram_size = req_size.
  - ram_wdata lane-replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
  - Each wdata handshake completes one beat and adds 4 to the beat address.
  - After the last beat → RESP with rsp_data = 0, rsp_last = 1. Stores produce one ack per request.
- RESP
  - rsp_valid = 1; rsp_data, rsp_last and rsp_fault stay stable until rsp_ready.
  - On handshake:
    - load with beats remaining → add 4 to the beat address, go to READ;
    - otherwise → IDLE.
  - rsp_last = 1 only on the final load beat.
- Outside READ, CAPT and WRITE: ram_we = 0; ram_addr and ram_size hold their last values.

## Timing
- Reset values:
  - state IDLE;
  - rsp_valid, rsp_last, rsp_fault, rsp_data = 0;
  - ram_we, wdata_ready = 0;
  - ram_addr = 0, ram_size = 10, ram_wdata = 0.
- Load: rsp_valid rises 4 cycles after the accept edge (CHECK, READ, CAPT, then RESP).
- Load bursts: each further beat takes 3 cycles after its rsp handshake (READ, CAPT, RESP).
- Store: one RAM write per cycle while wdata_valid stays high. The ack comes 1 cycle after the last write edge.
- Fault: rsp_valid rises 2 cycles after accept, with zero RAM activity.
- No new request is accepted before the final response handshake; req_ready = 0 outside IDLE.
- Reset during operation:
  - ram_we is gated by !rst in the same cycle;
  - any pending response is dropped and the block returns to IDLE;
  - req_ready returns to 1 in the first cycle after rst deasserts.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - the MEM_BYTES default.
  The RAM shares the size encodings.
- Sub-module lane_align (combinational) holds store lane replication and load sign/zero extension.
- The FSM, beat counter and address incrementer live in ram_access_ctrl.

## Test plan
- Byte store/load: store 0xA5 to 0x003 → one ram_we cycle with ram_size 00 and ram_wdata 0xA5A5A5A5. A signed byte load from 0x003 → rsp_data 0xFFFFFFA5, 4 cycles after accept; the unsigned load → 0x000000A5.
- Half store/load: store 0x8001 at 0x002 → ram_wdata 0x80018001. Unsigned load → 0x00008001; signed load → 0xFFFF8001.
- Store burst: 4 words to 0x010, with wdata_valid low for 2 cycles between beats 2 and 3 → writes at 0x010, 0x014, 0x018, 0x01C and exactly one ack.
- Load burst: 4 words from 0x010 → 4 responses, rsp_last on the 4th only. Holding rsp_ready low for 3 cycles on beat 2 → rsp_data stable and no RAM address advance.
- Faults: each of the following → a single response with rsp_fault = 1, rsp_data = 0, rsp_last = 1, and ram_we never asserted:
  - half at 0x001;
  - word at 0x002;
  - size 11;
  - count 0;
  - count 2 with byte size;
  - word burst at 0x3FC with count 2.
- Reset during operation: rst high during beat 2 of a 4-beat store → ram_we low that cycle, rsp_valid 0, req_ready 1 in the cycle after rst falls. The memory at 0x018 and 0x01C is left unchanged.
